// File: rtl/video_mixer.sv
// Final pixel compositor: text/sprite/background priority mix,
// text palette and control registers, frame-based text blink.
module video_mixer #(
  parameter int COLOR_W       = 4,
  parameter int BLINK_DEFAULT = 30
) (
  input  logic                 gpu_clk,
  input  logic                 rst,
  input  logic                 visible,
  input  logic                 in_vblank,
  input  logic                 text_color,
  input  logic                 text_valid,
  input  logic [3*COLOR_W-1:0] obj_rgb,
  input  logic                 obj_valid,
  input  logic [3*COLOR_W-1:0] bg_rgb,
  input  logic                 cfg_we,
  input  logic [2:0]           cfg_addr,
  input  logic [7:0]           cfg_data,
  output logic [COLOR_W-1:0]   out_r,
  output logic [COLOR_W-1:0]   out_g,
  output logic [COLOR_W-1:0]   out_b,
  output logic                 out_visible
);

  localparam int PW = 3 * COLOR_W;

  logic [PW-1:0] txt0_q, txt0_d;
  logic [PW-1:0] txt1_q, txt1_d;
  logic [7:0]    ctrl_q, ctrl_d;
  logic [5:0]    period_q, period_d;
  logic [5:0]    cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          vb_q;

  logic          s1_vis_q, s1_tc_q, s1_tv_q, s1_ov_q;
  logic [PW-1:0] s1_obj_q, s1_bg_q;

  logic [PW-1:0] pix_q, pix_d;
  logic          vis_q;

  logic          frame_edge;
  logic          text_eff, obj_eff;
  logic [PW-1:0] text_rgb;

  always_comb begin
    txt0_d   = txt0_q;
    txt1_d   = txt1_q;
    ctrl_d   = ctrl_q;
    period_d = period_q;
    if (cfg_we) begin
      unique case (cfg_addr)
        3'd0:    txt0_d[7:0]  = cfg_data;
        3'd1:    txt0_d[11:8] = cfg_data[3:0];
        3'd2:    txt1_d[7:0]  = cfg_data;
        3'd3:    txt1_d[11:8] = cfg_data[3:0];
        3'd4:    ctrl_d       = cfg_data;
        3'd5:    period_d     = cfg_data[5:0];
        default: ;
      endcase
    end
  end

  // Blink update reads period_q, so a same-cycle write takes effect later.
  always_comb begin
    frame_edge = in_vblank & ~vb_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    if (period_q == 6'd0) begin
      cnt_d   = 6'd0;
      phase_d = 1'b1;
    end else if (frame_edge) begin
      if (cnt_q >= period_q - 6'd1) begin
        cnt_d   = 6'd0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 6'd1;
      end
    end
  end

  always_comb begin
    text_eff = s1_tv_q & ctrl_q[0]
             & ~(ctrl_q[2] & ~phase_q & s1_tc_q);
    obj_eff  = s1_ov_q & ctrl_q[1];
    text_rgb = s1_tc_q ? txt1_q : txt0_q;
    pix_d    = s1_bg_q;
    if (!s1_vis_q) begin
      pix_d = '0;
    end else if (ctrl_q[3]) begin
      if (text_eff)     pix_d = text_rgb;
      else if (obj_eff) pix_d = s1_obj_q;
    end else begin
      if (obj_eff)       pix_d = s1_obj_q;
      else if (text_eff) pix_d = text_rgb;
    end
  end

  always_ff @(posedge gpu_clk or posedge rst) begin
    if (rst) begin
      txt0_q   <= '0;
      txt1_q   <= '1;
      ctrl_q   <= 8'h03;
      period_q <= 6'(BLINK_DEFAULT);
      cnt_q    <= 6'd0;
      phase_q  <= 1'b1;
      vb_q     <= 1'b0;
      s1_vis_q <= 1'b0;
      s1_tc_q  <= 1'b0;
      s1_tv_q  <= 1'b0;
      s1_ov_q  <= 1'b0;
      s1_obj_q <= '0;
      s1_bg_q  <= '0;
      pix_q    <= '0;
      vis_q    <= 1'b0;
    end else begin
      txt0_q   <= txt0_d;
      txt1_q   <= txt1_d;
      ctrl_q   <= ctrl_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      vb_q     <= in_vblank;
      s1_vis_q <= visible;
      s1_tc_q  <= text_color;
      s1_tv_q  <= text_valid;
      s1_ov_q  <= obj_valid;
      s1_obj_q <= obj_rgb;
      s1_bg_q  <= bg_rgb;
      pix_q    <= pix_d;
      vis_q    <= s1_vis_q;
    end
  end

  assign out_r       = pix_q[PW-1 -: COLOR_W];
  assign out_g       = pix_q[2*COLOR_W-1 -: COLOR_W];
  assign out_b       = pix_q[COLOR_W-1:0];
  assign out_visible = vis_q;

endmodule

// File: tb/tb_video_mixer.sv
// Directed bench for video_mixer: scoreboard of expected pixels,
// checked two cycles after each driven input.
module tb_video_mixer;

  logic        gpu_clk = 1'b0;
  logic        rst = 1'b1;
  logic        visible = 1'b0;
  logic        in_vblank = 1'b0;
  logic        text_color = 1'b0;
  logic        text_valid = 1'b0;
  logic [11:0] obj_rgb = '0;
  logic        obj_valid = 1'b0;
  logic [11:0] bg_rgb = '0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [7:0]  cfg_data = '0;
  logic [3:0]  out_r, out_g, out_b;
  logic        out_visible;

  video_mixer #(.COLOR_W(4), .BLINK_DEFAULT(30)) dut (
    .gpu_clk(gpu_clk), .rst(rst), .visible(visible),
    .in_vblank(in_vblank), .text_color(text_color),
    .text_valid(text_valid), .obj_rgb(obj_rgb),
    .obj_valid(obj_valid), .bg_rgb(bg_rgb),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_visible(out_visible)
  );

  always #5 gpu_clk = ~gpu_clk;

  typedef struct {
    int          due;
    logic [12:0] want;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  // Bench-side blink model
  int          m_period = 30;
  int          m_cnt = 0;
  logic        m_phase = 1'b1;
  logic [11:0] m_txt1 = 12'hFFF;

  always @(posedge gpu_clk) begin
    exp_t e;
    logic [12:0] got;
    cyc++;
    #1;
    if (sb.size() != 0 && sb[0].due <= cyc) begin
      e   = sb.pop_front();
      got = {out_visible, out_r, out_g, out_b};
      tests++;
      assert (e.due == cyc && got === e.want) else begin
        fails++;
        $error("FAIL %s got=%h exp=%h cyc=%0d",
               e.tag, got, e.want, cyc);
      end
    end
  end

  task automatic pix(input logic v, input logic tv, input logic tc,
                     input logic ov, input logic [11:0] orgb,
                     input logic [11:0] brgb, input logic [11:0] px,
                     input string tag);
    exp_t e;
    @(negedge gpu_clk);
    visible = v; text_valid = tv; text_color = tc;
    obj_valid = ov; obj_rgb = orgb; bg_rgb = brgb;
    e.due  = cyc + 2;
    e.want = {v, v ? px : 12'h000};
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic model_write(input logic [2:0] a, input logic [7:0] d);
    if (a == 3'd5) begin
      m_period = int'(d[5:0]);
      if (m_period == 0) begin
        m_cnt   = 0;
        m_phase = 1'b1;
      end
    end
    if (a == 3'd3) m_txt1[11:8] = d[3:0];
    if (a == 3'd2) m_txt1[7:0] = d;
  endtask

  task automatic model_edge();
    if (m_period != 0) begin
      if (m_cnt >= m_period - 1) begin
        m_cnt   = 0;
        m_phase = ~m_phase;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge gpu_clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    model_write(a, d);
    @(negedge gpu_clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse(input logic wr, input logic [2:0] a,
                       input logic [7:0] d);
    @(negedge gpu_clk);
    in_vblank = 1'b1;
    model_edge();
    if (wr) begin
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      model_write(a, d);
    end
    @(negedge gpu_clk);
    in_vblank = 1'b0;
    cfg_we    = 1'b0;
  endtask

  task automatic check_blink(input string tag);
    pix(1, 1, 1, 0, 12'h000, 12'h789,
        m_phase ? m_txt1 : 12'h789, tag);
    pix(1, 1, 0, 0, 12'h000, 12'h789, 12'h000, "txt0_never_hidden");
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++)
      @(posedge gpu_clk);
    #2;
    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL drain pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #12;
    tests++;
    assert ({out_visible, out_r, out_g, out_b} === 13'h0) else begin
      fails++;
      $error("FAIL reset_out got=%h exp=0",
             {out_visible, out_r, out_g, out_b});
    end
    @(negedge gpu_clk);
    rst = 1'b0;

    pix(1, 1, 1, 0, 12'h000, 12'h000, 12'hFFF, "rst_txt1");
    pix(1, 1, 0, 0, 12'h000, 12'h000, 12'h000, "rst_txt0");
    pix(0, 1, 1, 0, 12'h000, 12'h000, 12'h000, "rst_invis");
    drain();

    cfg_write(3'd3, 8'h0A);
    cfg_write(3'd2, 8'h5C);
    cfg_write(3'd4, 8'h0B);
    pix(1, 1, 1, 1, 12'h123, 12'h789, 12'hA5C, "text_over_obj");
    drain();
    cfg_write(3'd4, 8'h03);
    pix(1, 1, 1, 1, 12'h123, 12'h789, 12'h123, "obj_over_text");
    pix(1, 0, 1, 0, 12'h123, 12'h789, 12'h789, "bg_only");
    pix(0, 1, 1, 1, 12'h123, 12'h789, 12'h000, "invisible");
    for (int i = 0; i < 8; i++)
      pix(logic'(i[0] ^ i[2]), 0, 0, 0, 12'h000, 12'h789,
          12'h789, "vis_toggle");
    drain();

    cfg_write(3'd5, 8'd2);
    cfg_write(3'd4, 8'h07);
    for (int k = 1; k <= 6; k++) begin
      pulse(1'b0, 3'd0, 8'h00);
      check_blink($sformatf("blink_edge%0d", k));
    end
    drain();

    cfg_write(3'd5, 8'd0);
    for (int k = 0; k < 3; k++) begin
      pulse(1'b0, 3'd0, 8'h00);
      pix(1, 1, 1, 0, 12'h000, 12'h789, 12'hA5C, "period0_shown");
    end
    drain();

    cfg_write(3'd5, 8'd30);
    for (int k = 0; k < 10; k++) pulse(1'b0, 3'd0, 8'h00);
    check_blink("cnt10_shown");
    cfg_write(3'd5, 8'd4);
    pulse(1'b0, 3'd0, 8'h00);
    check_blink("lower_period_wrap");
    pulse(1'b0, 3'd0, 8'h00);
    pulse(1'b0, 3'd0, 8'h00);
    pulse(1'b1, 3'd5, 8'd2);
    check_blink("same_cycle_old_period");
    pulse(1'b0, 3'd0, 8'h00);
    check_blink("new_period_wrap");
    drain();

    pix(1, 1, 1, 0, 12'h000, 12'h789,
        m_phase ? m_txt1 : 12'h789, "pre_reset");
    drain();
    @(posedge gpu_clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    assert ({out_visible, out_r, out_g, out_b} === 13'h0) else begin
      fails++;
      $error("FAIL async_reset got=%h exp=0",
             {out_visible, out_r, out_g, out_b});
    end
    m_period = 30; m_cnt = 0; m_phase = 1'b1; m_txt1 = 12'hFFF;
    @(negedge gpu_clk);
    rst = 1'b0;
    pix(1, 1, 1, 0, 12'h000, 12'h789, 12'hFFF, "post_rst_txt1");
    pix(1, 1, 0, 0, 12'h000, 12'h789, 12'h000, "post_rst_txt0");
    pix(1, 1, 1, 1, 12'h123, 12'h789, 12'h123, "post_rst_ctrl");
    drain();
    cfg_write(3'd4, 8'h07);
    for (int k = 0; k < 29; k++) pulse(1'b0, 3'd0, 8'h00);
    check_blink("rst_period_29");
    pulse(1'b0, 3'd0, 8'h00);
    check_blink("rst_period_30");
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/video_mixer.md
Name: video_mixer

Overview:
- Pixel compositor directly downstream of the text layer: combines the text layer's 1-bit colour select and valid with the background and sprite layers' pixels, then drives final RGB444 to the video output.
- Holds CPU-programmable text palette and control registers and a frame-based text blink generator.
- Two-stage registered pipeline clocked on the GPU pixel clock.

Parameters:
- COLOR_W, 4, bits per RGB channel
- BLINK_DEFAULT, 30, reset value of the blink period register in frames

Ports:
- gpu_clk  input  1  pixel clock; all state is clocked on its rising edge
- rst  input  1  asynchronous, active-high reset
- visible  input  1  current pixel is in the active 256x240 area
- in_vblank  input  1  high during vertical blanking
- text_color  input  1  text colour select (0 = TXT0 palette, 1 = TXT1 palette)
- text_valid  input  1  text pixel is opaque
- obj_rgb  input  3*COLOR_W  sprite pixel colour {R,G,B}
- obj_valid  input  1  sprite pixel is opaque
- bg_rgb  input  3*COLOR_W  background pixel colour, always opaque
- cfg_we  input  1  config register write strobe
- cfg_addr  input  3  config register index
- cfg_data  input  8  config write data
- out_r, out_g, out_b  output  COLOR_W each  final pixel colour
- out_visible  output  1  visible, delayed to align with out_r/out_g/out_b

Behaviour:
- Config registers (write-only; writes to unused addresses 6-7 are ignored):
  - addr 0: TXT0[7:0] = {G,B}
  - addr 1: TXT0[11:8] = R, from cfg_data[3:0]
  - addr 2: TXT1[7:0] = {G,B}
  - addr 3: TXT1[11:8] = R, from cfg_data[3:0]
  - addr 4: CTRL. bit0 text_en, bit1 obj_en, bit2 blink_en, bit3 text_over_obj.
  - addr 5: BLINK_PERIOD[5:0]
- Reset values:
  - TXT0 = 12'h000, TXT1 = 12'hFFF
  - CTRL = 8'h03
  - BLINK_PERIOD = BLINK_DEFAULT
  - frame counter = 0, blink_phase = 1
  - both pipeline stages cleared
  - out_r/out_g/out_b = 0, out_visible = 0
- Config writes update on the rising edge where cfg_we is high. A new value first affects the stage-2 decision on the next clock edge.
- Stage 1 registers: visible, text_color, text_valid, obj_rgb, obj_valid, bg_rgb.
- Stage 2 resolves the pixel and registers the outputs. Total latency is 2 cycles from input to output; out_visible uses the same 2-cycle delay.
- Effective layer validity:
  - text_eff = text_valid & text_en & ~(blink_en & ~blink_phase & text_color). Blink hides only TXT1 text.
  - obj_eff = obj_valid & obj_en
- Priority:
  - text_over_obj = 1: text, then obj, then bg.
  - text_over_obj = 0: obj, then text, then bg.
- Text colour = TXT1 if text_color is 1, else TXT0.
- Stage-1 visible = 0 forces the stage-2 outputs to 0, regardless of the layer inputs.
- Blink generator:
  - A frame edge is a rising edge of in_vblank, detected with a 1-flop delay.
  - On a frame edge with BLINK_PERIOD != 0: if counter >= BLINK_PERIOD-1, set counter = 0 and toggle blink_phase; otherwise increment counter.
  - BLINK_PERIOD == 0: counter is held at 0 and blink_phase is forced to 1 (blink disabled).
  - Lowering BLINK_PERIOD below the current counter wraps on the next frame edge. The counter never runs past 63.
- blink_en = 0 does not stop the counter or phase. Only their effect on text pixels is masked.
- A config write and a frame edge in the same cycle: the blink update uses the pre-write BLINK_PERIOD.
- rst asserted mid-frame clears everything at once, including in-flight pipeline data. The first valid output appears 2 cycles after rst deasserts.
- No other state. The output is a pure function of the inputs delayed 2 cycles, the registers, and blink_phase.

Test Plan:
- Reset release, visible=1, text_valid=1, text_color=1, obj_valid=0 -> after 2 cycles out = F,F,F; with text_color=0 -> out = 0,0,0; out_visible tracks visible with 2-cycle delay.
- Write TXT1 = {addr3 8'h0A, addr2 8'h5C}, CTRL = 8'h0B, obj_valid=1 with obj_rgb 12'h123, text_valid=1, text_color=1 -> out = A,5,C. Write CTRL = 8'h03 -> out = 1,2,3. Both invalid with bg_rgb 12'h789 -> out = 7,8,9.
- Drive visible=0 with all layers valid -> out = 0,0,0 and out_visible = 0 two cycles later. Toggle visible every cycle -> out_visible reproduces the pattern delayed by exactly 2 cycles.
- Set BLINK_PERIOD = 2, CTRL = 8'h07, and pulse in_vblank 6 times:
  - TXT1 text is hidden after frame edges 2 and 6 and shown after edge 4.
  - TXT0 text is never hidden.
  - Period 0 -> TXT1 text is always shown.
- Let counter reach 10 with period 30, then write period 4 -> next frame edge wraps the counter to 0 and toggles phase. Write in the same cycle as an edge -> old period is used.
- Assert rst for 1 cycle mid-line while the pipeline is full and registers are modified -> outputs 0 immediately (asynchronous) and all registers return to their reset values.
